// File: rtl/fifo_pkg.sv
// Shared types and widths for the FIFO nibble-to-byte packer.
package fifo_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_HI  = 2'd1,
        S_OUT = 2'd2
    } state_e;

    // Places the first-read nibble low or high within the packed byte.
    function automatic logic [BYTE_W-1:0] pack_nibbles(
        input logic [NIBBLE_W-1:0] first_nib,
        input logic [NIBBLE_W-1:0] second_nib,
        input bit                  low_first
    );
        return low_first ? {second_nib, first_nib} : {first_nib, second_nib};
    endfunction

endpackage

// File: rtl/fifo_byte_packer.sv
// Packs pairs of 4-bit FIFO words into bytes with a valid/ready output and flush padding.
// Optional byte counter output enabled by defining FIFO_BYTE_PACKER_STATS_EN.
module fifo_byte_packer
    import fifo_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic [NIBBLE_W-1:0] fifo_data,
    input  logic                flush,
    output logic [BYTE_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_partial
`ifdef FIFO_BYTE_PACKER_STATS_EN
    ,
    output logic [15:0]         byte_count
`endif
);

    state_e              state_q, state_d;
    logic                rd_pending_q, rd_pending_d;
    logic                flush_req_q, flush_req_d;
    logic [NIBBLE_W-1:0] first_nib_q, first_nib_d;
    logic [BYTE_W-1:0]   out_data_q, out_data_d;
    logic                out_partial_q, out_partial_d;

    // A pending pad in S_HI must win over fetching a second nibble.
    assign fifo_rd_en = !reset
                      && (state_q == S_LO || state_q == S_HI)
                      && !fifo_empty
                      && !rd_pending_q
                      && !(state_q == S_HI && flush_req_q);

    assign out_valid   = (state_q == S_OUT);
    assign out_data    = out_data_q;
    assign out_partial = out_partial_q;

    always_comb begin
        // NOTE: every _d is given its hold value first so no branch can infer a latch.
        state_d       = state_q;
        first_nib_d   = first_nib_q;
        out_data_d    = out_data_q;
        out_partial_d = out_partial_q;
        rd_pending_d  = fifo_rd_en;
        flush_req_d   = flush_req_q | flush;

        case (state_q)
            S_LO: begin
                if (rd_pending_q) begin
                    first_nib_d = fifo_data;
                    state_d     = S_HI;
                end else if (flush_req_q) begin
                    flush_req_d = flush;
                end
            end
            S_HI: begin
                if (rd_pending_q) begin
                    out_data_d    = pack_nibbles(first_nib_q, fifo_data, LOW_FIRST);
                    out_partial_d = 1'b0;
                    state_d       = S_OUT;
                end else if (flush_req_q) begin
                    out_data_d    = pack_nibbles(first_nib_q, '0, LOW_FIRST);
                    out_partial_d = 1'b1;
                    flush_req_d   = flush;
                    state_d       = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_LO;
                end
            end
            default: state_d = S_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= S_LO;
            rd_pending_q  <= 1'b0;
            flush_req_q   <= 1'b0;
            first_nib_q   <= '0;
            out_data_q    <= '0;
            out_partial_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_pending_q  <= rd_pending_d;
            flush_req_q   <= flush_req_d;
            first_nib_q   <= first_nib_d;
            out_data_q    <= out_data_d;
            out_partial_q <= out_partial_d;
        end
    end

`ifdef FIFO_BYTE_PACKER_STATS_EN
    logic [15:0] byte_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_count_q <= '0;
        end else if (out_valid && out_ready) begin
            byte_count_q <= byte_count_q + 16'd1;
        end
    end

    assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer: both nibble orders, flush padding, back-pressure, reset mid-read.
module tb_fifo_byte_packer;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       out_ready;
    logic       fifo_empty;
    logic [3:0] fifo_data = 4'h0;

    logic       rd_en_lf, rd_en_hf;
    logic [7:0] out_data_lf, out_data_hf;
    logic       out_valid_lf, out_valid_hf;
    logic       out_partial_lf, out_partial_hf;
`ifdef FIFO_BYTE_PACKER_STATS_EN
    logic [15:0] byte_count_lf, byte_count_hf;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_bytes  = 0;

    always #5 clk = ~clk;

    fifo_byte_packer #(.LOW_FIRST(1'b1)) dut_lf (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (rd_en_lf),
        .fifo_data   (fifo_data),
        .flush       (flush),
        .out_data    (out_data_lf),
        .out_valid   (out_valid_lf),
        .out_ready   (out_ready),
        .out_partial (out_partial_lf)
`ifdef FIFO_BYTE_PACKER_STATS_EN
        ,
        .byte_count  (byte_count_lf)
`endif
    );

    // Second instance shares the stimulus; its read strobe mirrors the first one.
    fifo_byte_packer #(.LOW_FIRST(1'b0)) dut_hf (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (rd_en_hf),
        .fifo_data   (fifo_data),
        .flush       (flush),
        .out_data    (out_data_hf),
        .out_valid   (out_valid_hf),
        .out_ready   (out_ready),
        .out_partial (out_partial_hf)
`ifdef FIFO_BYTE_PACKER_STATS_EN
        ,
        .byte_count  (byte_count_hf)
`endif
    );

    // Upstream FIFO model: registered read data one cycle after an accepted read.
    logic [3:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rd_en_lf) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [8:0] lf_q[$];
    logic [8:0] hf_q[$];

    always @(posedge clk) begin
        if (reset) begin
            n_bytes <= 0;
        end else begin
            if (out_valid_lf && out_ready) begin
                lf_q.push_back({out_partial_lf, out_data_lf});
                n_bytes <= n_bytes + 1;
            end
            if (out_valid_hf && out_ready) hf_q.push_back({out_partial_hf, out_data_hf});
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] nib);
        mem[wr_ptr] = nib;
        wr_ptr = wr_ptr + 1;
    endtask

    // Waits for the next byte from both instances and checks its packing.
    task automatic expect_byte(input string tag, input logic [3:0] first_nib,
                               input logic [3:0] second_nib, input logic partial);
        int budget = 60;
        logic [8:0] v;
        while ((lf_q.size() == 0 || hf_q.size() == 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (lf_q.size() == 0 || hf_q.size() == 0) begin
            check({tag, ".timeout"}, 16'd0, 16'd1);
        end else begin
            v = lf_q.pop_front();
            check({tag, ".lf_data"}, 16'(v[7:0]), 16'({second_nib, first_nib}));
            check({tag, ".lf_partial"}, 16'(v[8]), 16'(partial));
            v = hf_q.pop_front();
            check({tag, ".hf_data"}, 16'(v[7:0]), 16'({first_nib, second_nib}));
            check({tag, ".hf_partial"}, 16'(v[8]), 16'(partial));
        end
    endtask

    initial begin
        int cyc;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("reset.out_valid", 16'(out_valid_lf), 16'd0);
        check("reset.out_data", 16'(out_data_lf), 16'h00);
        check("reset.out_partial", 16'(out_partial_lf), 16'd0);
        check("reset.state", 16'(dut_lf.state_q), 16'(S_LO));

        // Basic pair 3 then A, with first-byte latency from the first read.
        push(4'h3);
        push(4'hA);
        #1;
        check("reset.rd_en_held", 16'(rd_en_lf), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("basic.first_read", 16'(rd_en_lf), 16'd1);
        cyc = 0;
        while (!out_valid_lf && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("basic.latency", 16'(cyc), 16'd4);
        expect_byte("basic", 4'h3, 4'hA, 1'b0);

        // Single nibble left stranded in S_HI, then a flush pulse pads it.
        push(4'h5);
        repeat (6) @(negedge clk);
        check("stall.no_output", 16'(out_valid_lf), 16'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        expect_byte("flush_single", 4'h5, 4'h0, 1'b1);

        // Back-pressure: byte held for 10 cycles with more data waiting upstream.
        out_ready = 1'b0;
        push(4'h7);
        push(4'h8);
        push(4'h9);
        cyc = 0;
        while (!out_valid_lf && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold.out_valid", 16'(out_valid_lf), 16'd1);
            check("hold.out_data", 16'(out_data_lf), 16'h87);
            check("hold.rd_en", 16'(rd_en_lf), 16'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        expect_byte("hold", 4'h7, 4'h8, 1'b0);
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        expect_byte("flush_leftover", 4'h9, 4'h0, 1'b1);

        // Flush while the first read is outstanding: pad wins over a non-empty FIFO.
        repeat (2) @(negedge clk);
        push(4'h1);
        push(4'h2);
        push(4'h3);
        #1;
        check("prio.first_read", 16'(rd_en_lf), 16'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("prio.rd_en_blocked", 16'(rd_en_lf), 16'd0);
        check("prio.fifo_not_empty", 16'(fifo_empty), 16'd0);
        expect_byte("prio.padded", 4'h1, 4'h0, 1'b1);
        expect_byte("prio.next", 4'h2, 4'h3, 1'b0);

        // Reset on the cycle after a read: returned nibble must be discarded.
        repeat (4) @(negedge clk);
        push(4'hB);
        #1;
        check("rst.read_issued", 16'(rd_en_lf), 16'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst.rd_en_in_reset", 16'(rd_en_lf), 16'd0);
        @(negedge clk);
        check("rst.out_valid", 16'(out_valid_lf), 16'd0);
        check("rst.state", 16'(dut_lf.state_q), 16'(S_LO));
        check("rst.rd_pending", 16'(dut_lf.rd_pending_q), 16'd0);
        reset = 1'b0;
        push(4'hC);
        push(4'hD);
        expect_byte("rst.after", 4'hC, 4'hD, 1'b0);

        repeat (8) @(negedge clk);
        check("end.no_extra_lf", 16'(lf_q.size()), 16'd0);
        check("end.no_extra_hf", 16'(hf_q.size()), 16'd0);
`ifdef FIFO_BYTE_PACKER_STATS_EN
        check("stats.byte_count", byte_count_lf, 16'(n_bytes));
        check("stats.after_reset", byte_count_lf, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_byte_packer.md
FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

Interface
REQ-001 SHALL have parameter LOW_FIRST, default 1: first nibble read lands in out_data[3:0] (1) or out_data[7:4] (0).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-005 SHALL have port fifo_rd_en  output  1  read strobe to upstream FIFO.
REQ-006 SHALL have port fifo_data  input  4  upstream FIFO registered read data, valid one cycle after an accepted read.
REQ-007 SHALL have port flush  input  1  pulse: emit a pending half byte zero-padded.
REQ-008 SHALL have port out_data  output  8  packed byte.
REQ-009 SHALL have port out_valid  output  1  out_data holds a byte.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the byte.
REQ-011 SHALL have port out_partial  output  1  current byte is flush-padded (valid only with out_valid).

Function
REQ-012 SHALL implement FSM states S_LO (need first nibble), S_HI (need second nibble) and S_OUT (byte held).
REQ-013 SHALL keep at most one read outstanding: rd_pending set on the cycle fifo_rd_en=1, cleared the next cycle.
REQ-014 SHALL drive fifo_rd_en = !reset && (S_LO || S_HI) && !fifo_empty && !rd_pending && !(S_HI && flush_req), combinationally.
REQ-015 SHALL capture fifo_data on the cycle rd_pending=1: in S_LO store the first nibble and go to S_HI; in S_HI store the second nibble and go to S_OUT with out_partial=0.
REQ-016 SHALL sustain one nibble per 2 cycles at best, giving a first byte in 4 cycles from the first read.
REQ-017 SHALL hold out_valid, out_data and out_partial stable in S_OUT until out_valid && out_ready, then return to S_LO next cycle.
REQ-018 SHALL never deassert out_valid without a handshake, and SHALL issue no reads in S_OUT.
REQ-019 SHALL register flush into sticky flush_req, OR'd with a new flush each cycle.
REQ-020 SHALL, in S_HI with rd_pending=0 and flush_req=1, go to S_OUT with the missing nibble = 4'h0, set out_partial=1 and clear flush_req; this has priority over a new read even when fifo_empty=0.
REQ-021 SHALL clear flush_req without output when in S_LO with rd_pending=0, so nothing is pending.
REQ-022 SHALL, on a flush arriving in S_LO with a read outstanding, capture the nibble, move to S_HI, then pad on the following cycle.
REQ-023 SHALL, on a flush arriving in S_OUT, keep flush_req until the state returns to S_LO with rd_pending=0 and clear it there (REQ-021).
REQ-024 SHALL place nibbles per LOW_FIRST: first nibble at [3:0] when 1, at [7:4] when 0.
REQ-025 SHALL not stall on fifo_empty while a read is outstanding, because data returns regardless.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set state=S_LO, rd_pending=0, flush_req=0, out_valid=0, out_data=8'h00, out_partial=0 and nibble registers to 0.
REQ-027 SHALL drop any outstanding read on reset mid-operation; the nibble returned by the FIFO is ignored.
REQ-028 SHALL hold fifo_rd_en=0 while reset=1.

Configuration
REQ-029 SHALL, with FIFO_BYTE_PACKER_STATS_EN defined, add output byte_count [15:0], reset to 0, incrementing by 1 (wrapping 16'hFFFF->0) on every out_valid && out_ready.
REQ-030 SHALL, without FIFO_BYTE_PACKER_STATS_EN, have no byte_count port and no counter logic, with all other behaviour identical.

Structure
REQ-031 SHALL take the state enum (S_LO/S_HI/S_OUT), NIBBLE_W=4 and BYTE_W=8 from shared package fifo_pkg.
REQ-032 SHALL be a single module without sub-modules, instantiated directly downstream of the synchronous FIFO.

Verification
REQ-033 SHALL cover: FIFO holds 4'h3 then 4'hA, out_ready=1, LOW_FIRST=1 -> one byte 8'hA3, out_partial=0.
REQ-034 SHALL cover: the same data with LOW_FIRST=0 -> 8'h3A.
REQ-035 SHALL cover: single nibble 4'h5 then flush pulse -> byte 8'h05, out_partial=1 (LOW_FIRST=1).
REQ-036 SHALL cover: out_ready=0 for 10 cycles with a byte held -> out_valid stays 1, out_data unchanged, fifo_rd_en=0 throughout.
REQ-037 SHALL cover: flush in S_HI with fifo_empty=0 -> padded byte emitted first, remaining nibble starts the next byte.
REQ-038 SHALL cover: reset asserted the cycle after fifo_rd_en -> next cycle out_valid=0, state S_LO, and the returned nibble absent from later bytes.
